matcher_lookup_arb: RTL

Shares the single matcher lookup port (lookup request / header in, action ack / hit / data out) among NUM_REQ header-parser requesters. Uses round-robin arbitration and keeps up to MAX_OUTSTANDING lookups in flight. An in-order tag FIFO steers each result back to the requester that issued it. A RUN/DRAIN/PAUSED controller quiesces lookups so software can rewrite CAM/LUT entries with no lookup in flight.

---
 rtl/matcher_lookup_arb_if.sv | 33 +++
 rtl/matcher_lookup_arb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/matcher_lookup_arb_if.sv
// Requester and matcher-side bus bundle for the shared matcher lookup port.
// The slave modport is taken by the arbiter; master is the environment view.
interface matcher_lookup_arb_if #(
    parameter int NUM_REQ   = 4,
    parameter int HDR_WIDTH = 240,
    parameter int ACT_WIDTH = 320
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*HDR_WIDTH-1:0] req_hdr;
    logic [NUM_REQ-1:0]           req_grant;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic                         rsp_hit;
    logic [ACT_WIDTH-1:0]         rsp_data;
    logic                         lookup_req;
    logic [HDR_WIDTH-1:0]         lookup_cmp_data;
    logic                         lookup_ack;
    logic                         lookup_hit;
    logic [ACT_WIDTH-1:0]         lookup_data;

    modport slave (
        input  req_valid, req_hdr,
        input  lookup_ack, lookup_hit, lookup_data,
        output req_grant, rsp_valid, rsp_hit, rsp_data,
        output lookup_req, lookup_cmp_data
    );

    modport master (
        output req_valid, req_hdr,
        output lookup_ack, lookup_hit, lookup_data,
        input  req_grant, rsp_valid, rsp_hit, rsp_data,
        input  lookup_req, lookup_cmp_data
    );
endinterface

// File: rtl/matcher_lookup_arb.sv
// Round-robin sharing of one in-order matcher lookup port among NUM_REQ
// header parsers, with a tag FIFO for result steering and a drain/pause FSM.
module matcher_lookup_arb #(
    parameter int NUM_REQ         = 4,
    parameter int HDR_WIDTH       = 240,
    parameter int ACT_WIDTH       = 320,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 255,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1,
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic          clk,
    input  logic          reset,
    matcher_lookup_arb_if.slave bus,
    input  logic          lookup_en,
    output logic          drained,
    output logic [OW-1:0] outstanding,
    input  logic          err_clear,
    output logic          err_spurious,
    output logic          err_timeout
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [IW-1:0]        rr_q;
    logic [IW-1:0]        gnt_idx;
    logic                 gnt_any;
    logic                 can_grant;
    logic                 push;
    logic                 pop;
    logic                 spur;
    logic                 flush;
    logic [NUM_REQ-1:0]   grant;
    logic [HDR_WIDTH-1:0] sel_hdr;

    logic [IW-1:0]        tag_mem [MAX_OUTSTANDING];
    logic [AW-1:0]        wr_q;
    logic [AW-1:0]        rd_q;
    logic [IW-1:0]        head;
    logic [OW-1:0]        out_q;
    logic [OW-1:0]        out_d;
    logic [15:0]          tmo_q;

    logic                 lreq_q;
    logic [HDR_WIDTH-1:0] lcmp_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic                 rsp_hit_q;
    logic [ACT_WIDTH-1:0] rsp_data_q;
    logic                 err_sp_q;
    logic                 err_to_q;

    assign head = tag_mem[rd_q];
    assign pop  = bus.lookup_ack && (out_q != '0);
    assign spur = bus.lookup_ack && (out_q == '0);

    // No ack for TIMEOUT cycles with lookups pending: give up on all of them.
    assign flush = (out_q != '0) && !bus.lookup_ack
                && (tmo_q == 16'(TIMEOUT - 1));

    // A same-cycle ack never frees a slot, so only out_q gates the grant.
    assign can_grant = !reset && (state_q == RUN) && lookup_en
                    && (out_q < OW'(MAX_OUTSTANDING)) && !flush;

    always_comb begin
        int idx;
        logic [IW-1:0] ii;
        idx     = 0;
        ii      = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            ii = IW'(idx);
            if (!gnt_any && bus.req_valid[ii]) begin
                gnt_any = 1'b1;
                gnt_idx = ii;
            end
        end
    end

    always_comb begin
        sel_hdr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IW'(i))
                sel_hdr = bus.req_hdr[i*HDR_WIDTH +: HDR_WIDTH];
        end
    end

    assign push  = gnt_any && can_grant;
    assign grant = push ? (NUM_REQ'(1) << gnt_idx) : '0;

    always_comb begin
        out_d = out_q;
        if (flush)
            out_d = '0;
        else if (push && !pop)
            out_d = out_q + OW'(1);
        else if (pop && !push)
            out_d = out_q - OW'(1);
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            (state_q == RUN): begin
                if (!lookup_en) state_d = DRAIN;
            end
            (state_q == DRAIN): begin
                if (lookup_en)
                    state_d = RUN;
                else if (out_d == '0)
                    state_d = PAUSED;
            end
            (state_q == PAUSED): begin
                if (lookup_en) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_q] <= gnt_idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            rr_q        <= IW'(NUM_REQ - 1);
            wr_q        <= '0;
            rd_q        <= '0;
            out_q       <= '0;
            tmo_q       <= '0;
            lreq_q      <= 1'b0;
            lcmp_q      <= '0;
            rsp_valid_q <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_data_q  <= '0;
            err_sp_q    <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            lreq_q  <= push;
            if (push) begin
                rr_q   <= gnt_idx;
                lcmp_q <= sel_hdr;
            end
            if (flush) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push) wr_q <= wr_q + AW'(1);
                if (pop)  rd_q <= rd_q + AW'(1);
            end
            if (bus.lookup_ack || (out_q == '0) || flush)
                tmo_q <= '0;
            else
                tmo_q <= tmo_q + 16'd1;
            rsp_valid_q <= pop ? (NUM_REQ'(1) << head) : '0;
            if (pop) begin
                rsp_hit_q  <= bus.lookup_hit;
                rsp_data_q <= bus.lookup_data;
            end
            err_sp_q <= spur  | (err_sp_q & ~err_clear);
            err_to_q <= flush | (err_to_q & ~err_clear);
        end
    end

    assign bus.req_grant       = grant;
    assign bus.lookup_req      = lreq_q;
    assign bus.lookup_cmp_data = lcmp_q;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_hit         = rsp_hit_q;
    assign bus.rsp_data        = rsp_data_q;

    assign outstanding  = out_q;
    assign drained      = (state_q == PAUSED) && !lookup_en;
    assign err_spurious = err_sp_q;
    assign err_timeout  = err_to_q;

endmodule
